ddr3_read_arbiter: RTL and testbench

Shares the single DDR3 EMIF read port between two read requesters: a header/config reader on port 0 and the frame-pixel reader on port 1. Each read command is one beat (burst count 1). A tag FIFO records the requester of every command in flight and routes each returned 256-bit beat back to its owner. The block sits between the EMIF controller and the DDR3 user-logic readers, in the `ddr3_emif_clk` domain.

---
 rtl/ddr3_read_arbiter.sv | 158 +++++++++++++++
 tb/tb_ddr3_read_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_read_arbiter.sv
// ddr3_read_arbiter: shares the DDR3 EMIF read port between two one-beat readers and routes
// returned beats through a tag FIFO. Define DDR3_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module ddr3_read_arbiter #(
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 256,
  parameter int MAX_OUTST = 16
) (
  input  logic                        ddr3_emif_clk,
  input  logic                        ddr3_emif_rst,
  input  logic                        r0_req,
  input  logic [ADDR_W-1:0]           r0_addr,
  output logic                        r0_ack,
  output logic [DATA_W-1:0]           r0_rdata,
  output logic                        r0_rdata_valid,
  input  logic                        r1_req,
  input  logic [ADDR_W-1:0]           r1_addr,
  output logic                        r1_ack,
  output logic [DATA_W-1:0]           r1_rdata,
  output logic                        r1_rdata_valid,
  input  logic                        ddr3_emif_ready,
  output logic                        ddr3_emif_read,
  output logic [ADDR_W-1:0]           ddr3_emif_addr,
  output logic [7:0]                  ddr3_emif_burst_count,
  input  logic [DATA_W-1:0]           ddr3_emif_read_data,
  input  logic                        ddr3_emif_rddata_valid,
  output logic [$clog2(MAX_OUTST):0]  outstanding,
  output logic                        err_unexpected
);

  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = PTR_W + 1;

  logic              cmd_valid;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_id;
`ifndef DDR3_ARB_FIXED_PRIO_EN
  logic              last_id;
`endif

  logic [MAX_OUTST-1:0] tag_mem;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     fifo_cnt;

  logic              accept;
  logic              pop;
  logic              unexpected;
  logic              slot_free;
  logic              room;
  logic [CNT_W-1:0]  post_pop;
  logic              grant;
  logic              grant_id;

  assign ddr3_emif_read        = cmd_valid;
  assign ddr3_emif_addr        = cmd_addr;
  assign ddr3_emif_burst_count = 8'd1;

  assign accept     = cmd_valid && ddr3_emif_ready;
  assign pop        = ddr3_emif_rddata_valid && (fifo_cnt != '0);
  assign unexpected = ddr3_emif_rddata_valid && (fifo_cnt == '0);
  assign slot_free  = !cmd_valid || accept;
  // A return in this cycle frees a slot for a grant in the same cycle.
  assign post_pop   = outstanding - {{PTR_W{1'b0}}, pop};
  assign room       = post_pop < CNT_W'(MAX_OUTST);

  always_comb begin
    grant    = 1'b0;
    grant_id = 1'b0;
    if (!ddr3_emif_rst && slot_free && room) begin
`ifdef DDR3_ARB_FIXED_PRIO_EN
      if (r0_req) begin
        grant    = 1'b1;
        grant_id = 1'b0;
      end else if (r1_req) begin
        grant    = 1'b1;
        grant_id = 1'b1;
      end
`else
      if (r0_req && r1_req) begin
        grant    = 1'b1;
        grant_id = !last_id;
      end else if (r0_req) begin
        grant    = 1'b1;
        grant_id = 1'b0;
      end else if (r1_req) begin
        grant    = 1'b1;
        grant_id = 1'b1;
      end
`endif
    end
  end

  assign r0_ack = grant && !grant_id;
  assign r1_ack = grant && grant_id;

  // Command register, tag FIFO control and outstanding count
  always_ff @(posedge ddr3_emif_clk) begin
    if (ddr3_emif_rst) begin
      cmd_valid   <= 1'b0;
      cmd_addr    <= '0;
      cmd_id      <= 1'b0;
`ifndef DDR3_ARB_FIXED_PRIO_EN
      last_id     <= 1'b1;
`endif
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      outstanding <= '0;
    end else begin
      if (grant) begin
        cmd_valid <= 1'b1;
        cmd_addr  <= grant_id ? r1_addr : r0_addr;
        cmd_id    <= grant_id;
`ifndef DDR3_ARB_FIXED_PRIO_EN
        last_id   <= grant_id;
`endif
      end else if (accept) begin
        cmd_valid <= 1'b0;
      end
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      case ({grant, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge ddr3_emif_clk) begin
    if (accept) tag_mem[wr_ptr] <= cmd_id;
  end

  // Return stage: data to both ports, valid only to the tagged owner
  always_ff @(posedge ddr3_emif_clk) begin
    if (ddr3_emif_rst) begin
      r0_rdata       <= '0;
      r1_rdata       <= '0;
      r0_rdata_valid <= 1'b0;
      r1_rdata_valid <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      r0_rdata_valid <= pop && !tag_mem[rd_ptr];
      r1_rdata_valid <= pop &&  tag_mem[rd_ptr];
      if (pop) begin
        r0_rdata <= ddr3_emif_read_data;
        r1_rdata <= ddr3_emif_read_data;
      end
      if (unexpected) err_unexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr3_read_arbiter.sv
// tb_ddr3_read_arbiter: randomized requesters and EMIF model, a per-cycle reference of grants
// and in-flight tags, and a scoreboard that checks every returned beat against its owner.
module tb_ddr3_read_arbiter;
  localparam int AW = 22;
  localparam int DW = 256;
  localparam int MAXO = 16;

  typedef struct { int port; logic [DW-1:0] data; int cyc; } exp_t;
  typedef struct { int due; logic [DW-1:0] data; } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_req, r1_req, r0_ack, r1_ack;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          r0_rdata_valid, r1_rdata_valid;
  logic          emif_ready, emif_read, emif_rvalid;
  logic [AW-1:0] emif_addr;
  logic [7:0]    emif_bc;
  logic [DW-1:0] emif_rdata;
  logic [$clog2(MAXO):0] outstanding;
  logic          err_unexpected;

  ddr3_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MAXO)) dut (
    .ddr3_emif_clk(clk), .ddr3_emif_rst(rst),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r0_rdata_valid(r0_rdata_valid),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .r1_rdata_valid(r1_rdata_valid),
    .ddr3_emif_ready(emif_ready), .ddr3_emif_read(emif_read), .ddr3_emif_addr(emif_addr),
    .ddr3_emif_burst_count(emif_bc), .ddr3_emif_read_data(emif_rdata),
    .ddr3_emif_rddata_valid(emif_rvalid), .outstanding(outstanding),
    .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus knobs
  int req_pct[2], issue_left[2], next_addr[2];
  int ready_pct, ret_pct, ret_left, ret_delay;
  bit ab_mode, rst_now, rec_en, mon_en;

  // reference state: pending command, in-flight owners in accept order
  bit            m_cv;
  logic [AW-1:0] m_ca;
  int            m_cid, m_last;
  bit            m_err;
  int            m_tags[$];
  bit            rq[2];
  logic [AW-1:0] ra[2];
  beat_t         emif_q[$];
  exp_t          exp_q[$];
  int            ack0_cnt, ack1_cnt;
  logic          last_dut_ack1;
  logic [AW-1:0] rec[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [DW-1:0] gen_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    if (ab_mode) d = {(DW / 8){8'hAB}};
    return d;
  endfunction

  task automatic model_step();
    int  m_out, w;
    bit  accept, pop;
    beat_t b;
    m_out = m_tags.size() + int'(m_cv);
    chk("emif_read", 256'(emif_read), 256'(m_cv));
    if (m_cv) chk("emif_addr", 256'(emif_addr), 256'(m_ca));
    chk("outstanding", 256'(outstanding), 256'(m_out));
    chk("err_unexpected", 256'(err_unexpected), 256'(m_err));
    chk("burst_count", 256'(emif_bc), 256'(1));
    if (r0_ack === 1'b1) ack0_cnt++;
    if (r1_ack === 1'b1) ack1_cnt++;
    last_dut_ack1 = r1_ack;
    if (rst_now) begin
      chk("ack0_in_reset", 256'(r0_ack), 256'(0));
      chk("ack1_in_reset", 256'(r1_ack), 256'(0));
      m_cv = 0; m_ca = '0; m_cid = 0; m_last = 1; m_err = 0;
      m_tags.delete();
      return;
    end
    accept = m_cv && emif_ready;
    pop    = emif_rvalid && (m_tags.size() > 0);
    if (emif_rvalid && m_tags.size() == 0) m_err = 1;
    w = -1;
    if ((!m_cv || accept) && (m_out - int'(pop)) < MAXO) begin
`ifdef DDR3_ARB_FIXED_PRIO_EN
      if (rq[0]) w = 0;
      else if (rq[1]) w = 1;
`else
      if (rq[0] && rq[1]) w = 1 - m_last;
      else if (rq[0]) w = 0;
      else if (rq[1]) w = 1;
`endif
    end
    chk("r0_ack", 256'(r0_ack), 256'(w == 0));
    chk("r1_ack", 256'(r1_ack), 256'(w == 1));
    if (accept) begin
      m_tags.push_back(m_cid);
      b.due = cyc + ret_delay;
      b.data = gen_data();
      emif_q.push_back(b);
      if (rec_en && rec.size() < 4) rec.push_back(emif_addr);
      m_cv = 0;
    end
    if (pop) exp_q.push_back('{port: m_tags.pop_front(), data: emif_rdata, cyc: cyc + 1});
    if (w >= 0) begin
      m_cv = 1; m_ca = ra[w]; m_cid = w; m_last = w; rq[w] = 0;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!rq[p] && issue_left[p] != 0 && int'($urandom_range(99)) < req_pct[p]) begin
          rq[p] = 1;
          ra[p] = AW'(next_addr[p]);
          next_addr[p]++;
          if (issue_left[p] > 0) issue_left[p]--;
        end
      end
      rst        = rst_now;
      r0_req     = rq[0];
      r0_addr    = ra[0];
      r1_req     = rq[1];
      r1_addr    = ra[1];
      emif_ready = int'($urandom_range(99)) < ready_pct;
      emif_rvalid = 1'b0;
      emif_rdata  = gen_data();
      if (!rst_now && emif_q.size() > 0 && ret_left != 0 && cyc >= emif_q[0].due &&
          int'($urandom_range(99)) < ret_pct) begin
        emif_rvalid = 1'b1;
        emif_rdata  = emif_q[0].data;
        void'(emif_q.pop_front());
        if (ret_left > 0) ret_left--;
      end
      #1;
      model_step();
    end
  endtask

  task automatic drain();
    req_pct[0] = 0; req_pct[1] = 0;
    ready_pct = 100; ret_pct = 100; ret_left = -1; ret_delay = 1;
    run(60);
  endtask

  // scoreboard monitor
  initial begin
    exp_t e;
    logic ok;
    wait (mon_en);
    forever begin
      @(negedge clk);
      #2;
      if (r0_rdata_valid === 1'b1 || r1_rdata_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL spurious_valid: got r0v=%0b r1v=%0b want none (cycle %0d)",
                   r0_rdata_valid, r1_rdata_valid, cyc);
        end else begin
          e = exp_q.pop_front();
          ok = (e.port == 0) ? (r0_rdata_valid === 1'b1 && r1_rdata_valid === 1'b0 &&
                                r0_rdata === e.data)
                             : (r1_rdata_valid === 1'b1 && r0_rdata_valid === 1'b0 &&
                                r1_rdata === e.data);
          if (!ok || e.cyc != cyc) begin
            n_bad++;
            $display("FAIL return_beat: got r0v=%0b r1v=%0b cyc=%0d data=%0h want port%0d cyc=%0d data=%0h",
                     r0_rdata_valid, r1_rdata_valid, cyc,
                     (e.port == 0) ? r0_rdata : r1_rdata, e.port, e.cyc, e.data);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missing_valid: got none want port%0d at cycle %0d", exp_q[0].port, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; r0_req = 0; r1_req = 0; r0_addr = '0; r1_addr = '0;
    emif_ready = 0; emif_rvalid = 0; emif_rdata = '0;
    m_cv = 0; m_ca = '0; m_cid = 0; m_last = 1; m_err = 0;
    rq[0] = 0; rq[1] = 0; ra[0] = '0; ra[1] = '0;
    req_pct[0] = 0; req_pct[1] = 0; issue_left[0] = 0; issue_left[1] = 0;
    next_addr[0] = 0; next_addr[1] = 0;
    ready_pct = 0; ret_pct = 0; ret_left = -1; ret_delay = 1;
    ab_mode = 0; rec_en = 0; mon_en = 0;
    repeat (2) @(posedge clk);
    rst_now = 1;
    run(1);
    chk("rst_r0_rdata", r0_rdata, '0);
    chk("rst_r1_rdata", r1_rdata, '0);
    chk("rst_r0_valid", 256'(r0_rdata_valid), 256'(0));
    chk("rst_r1_valid", 256'(r1_rdata_valid), 256'(0));
    chk("rst_emif_addr", 256'(emif_addr), 256'(0));
    rst_now = 0;
    mon_en = 1;

    // single read, AB pattern returned 12 cycles after accept
    issue_left[0] = 1; req_pct[0] = 100; next_addr[0] = 8;
    ready_pct = 100; ret_pct = 100; ret_delay = 12; ab_mode = 1;
    run(20);
    ab_mode = 0;
    drain();

    // contention from a fresh reset
    rst_now = 1; run(2); rst_now = 0;
    issue_left[0] = -1; issue_left[1] = -1; req_pct[0] = 100; req_pct[1] = 100;
    next_addr[0] = 0; next_addr[1] = 'h100;
    ready_pct = 100; ret_pct = 50; ret_delay = 2; rec_en = 1;
    run(200);
    rec_en = 0;
    chk("contention_cnt", 256'(rec.size()), 256'(4));
    while (rec.size() < 4) rec.push_back('1);
`ifdef DDR3_ARB_FIXED_PRIO_EN
    chk("contention_a0", 256'(rec[0]), 256'(0));
    chk("contention_a1", 256'(rec[1]), 256'(1));
    chk("contention_a2", 256'(rec[2]), 256'(2));
    chk("contention_a3", 256'(rec[3]), 256'(3));
`else
    chk("contention_a0", 256'(rec[0]), 256'(0));
    chk("contention_a1", 256'(rec[1]), 256'('h100));
    chk("contention_a2", 256'(rec[2]), 256'(1));
    chk("contention_a3", 256'(rec[3]), 256'('h101));
`endif
    drain();

    // random traffic
    req_pct[0] = 60; req_pct[1] = 60; ready_pct = 70; ret_pct = 50; ret_delay = 3;
    run(400);
    drain();

    // backpressure: ready low for the stalled cycles
    issue_left[0] = 2; issue_left[1] = 0; req_pct[0] = 100; ready_pct = 0;
    ack0_cnt = 0;
    run(7);
    chk("stall_acks", 256'(ack0_cnt), 256'(1));
    chk("stall_outstanding", 256'(outstanding), 256'(1));
    ready_pct = 100;
    run(5);
    drain();

    // full: port 1 streams with returns withheld
    issue_left[0] = 0; issue_left[1] = -1; req_pct[1] = 100;
    ready_pct = 100; ret_pct = 0; ret_delay = 1; ack1_cnt = 0;
    run(25);
    chk("full_acks", 256'(ack1_cnt), 256'(MAXO));
    chk("full_outstanding", 256'(outstanding), 256'(MAXO));
    ret_pct = 100; ret_left = 1;
    run(1);
    chk("full_regrant", 256'(last_dut_ack1), 256'(1));
    issue_left[1] = 0;
    drain();

    // reset with reads in flight
    issue_left[0] = 4; req_pct[0] = 100; ready_pct = 100; ret_pct = 0;
    run(8);
    chk("inflight_outstanding", 256'(outstanding), 256'(4));
    rst_now = 1; run(1); rst_now = 0;
    ret_pct = 100; ret_left = -1;
    run(10);
    chk("post_rst_err", 256'(err_unexpected), 256'(1));
    chk("post_rst_outstanding", 256'(outstanding), 256'(0));
    chk("post_rst_beats_left", 256'(emif_q.size()), 256'(0));
    run(3);
    chk("scoreboard_empty", 256'(exp_q.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
